inv_key_expansion: RTL and testbench

Iterative AES-128 inverse key schedule for the decryption datapath. Accepts the final round key (round `NR`) and walks the schedule backwards, emitting one round key per step in descending order, ending with the original cipher key (round 0). It feeds the inverse-cipher rounds, which consume keys in reverse order. It uses the same `block` type (128-bit, `def_pkg`) as the forward key expansion.

---
 rtl/inv_key_expansion.sv | 187 ++++++++++++++++++
 tb/tb_inv_key_expansion.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_expansion.sv
// rtl/inv_key_expansion.sv - AES-128 inverse key schedule, round NR down to 0; define INV_KEY_EXPANSION_SBOX_PIPE_EN to register each step after SubWord
package def_pkg;
  typedef logic [127:0] block;
endpackage

module inv_key_expansion
  import def_pkg::*;
#(
  parameter int NR        = 10,
  parameter bit EMIT_LAST = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_tx_en,
  input  block       i_key,
  input  logic       i_stall,
  output logic       o_busy,
  output logic       o_tx_en,
  output block       o_round_key,
  output logic [3:0] o_round,
  output logic       o_last
);

  if (NR != 10) begin : g_nr_unsupported
    $error("inv_key_expansion: only NR=10 (AES-128) is supported");
  end

  localparam logic [3:0] NR_R = 4'(NR);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(W3 ^ W2)): the only S-box dependent part of a step.
  function automatic logic [31:0] subrot(input block k);
    logic [31:0] p3;
    p3 = k[31:0] ^ k[63:32];
    return {sbox(p3[23:16]), sbox(p3[15:8]), sbox(p3[7:0]), sbox(p3[31:24])};
  endfunction

  // XOR network that turns round r key plus its SubWord term into round r-1 key.
  function automatic block finish(input block k, input logic [31:0] s, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    return {w0 ^ s ^ {rcon(r), 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  endfunction

`ifndef INV_KEY_EXPANSION_SBOX_PIPE_EN
  function automatic block step(input block k, input logic [3:0] r);
    return finish(k, subrot(k), r);
  endfunction
`endif

  typedef enum logic [1:0] {
`ifdef INV_KEY_EXPANSION_SBOX_PIPE_EN
    BUBBLE,
`endif
    IDLE,
    RUN
  } state_t;

  state_t      state_q, state_d;
  block        key_q, key_d;
  logic [3:0]  round_q, round_d;
  logic        tx_en_q, tx_en_d;
`ifdef INV_KEY_EXPANSION_SBOX_PIPE_EN
  logic [31:0] sub_q, sub_d;
`endif

  // Next-state and datapath selection; every register holds unless a branch moves it.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    tx_en_d = tx_en_q;
`ifdef INV_KEY_EXPANSION_SBOX_PIPE_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_tx_en) begin
          state_d = RUN;
          tx_en_d = 1'b1;
          if (EMIT_LAST) begin
            key_d   = i_key;
            round_d = NR_R;
          end else begin
`ifdef INV_KEY_EXPANSION_SBOX_PIPE_EN
            // First step goes through the bubble, so round NR-1 shows one cycle later.
            key_d   = i_key;
            round_d = NR_R;
            sub_d   = subrot(i_key);
            tx_en_d = 1'b0;
            state_d = BUBBLE;
`else
            key_d   = step(i_key, NR_R);
            round_d = NR_R - 4'd1;
`endif
          end
        end
      end
      RUN: begin
        if (tx_en_q && !i_stall) begin
          if (round_q != 4'd0) begin
`ifdef INV_KEY_EXPANSION_SBOX_PIPE_EN
            sub_d   = subrot(key_q);
            tx_en_d = 1'b0;
            state_d = BUBBLE;
`else
            key_d   = step(key_q, round_q);
            round_d = round_q - 4'd1;
`endif
          end else begin
            tx_en_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
`ifdef INV_KEY_EXPANSION_SBOX_PIPE_EN
      BUBBLE: begin
        // Round counter still names the key being stepped, so Rcon indexes correctly.
        key_d   = finish(key_q, sub_q, round_q);
        round_d = round_q - 4'd1;
        tx_en_d = 1'b1;
        state_d = RUN;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset clearing everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      tx_en_q <= 1'b0;
`ifdef INV_KEY_EXPANSION_SBOX_PIPE_EN
      sub_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      tx_en_q <= tx_en_d;
`ifdef INV_KEY_EXPANSION_SBOX_PIPE_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_tx_en     = tx_en_q;
  assign o_round_key = key_q;
  assign o_round     = round_q;
  assign o_last      = tx_en_q & (round_q == 4'd0);

endmodule

// File: tb/tb_inv_key_expansion.sv
// tb/tb_inv_key_expansion.sv - self-checking bench for inv_key_expansion (EMIT_LAST=1 and EMIT_LAST=0 side by side)
module tb_inv_key_expansion;

`ifdef INV_KEY_EXPANSION_SBOX_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  localparam logic [127:0] K_TKF  = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clock = 1'b0;
  logic         reset;
  logic         i_tx_en;
  logic         i_stall;
  logic [127:0] i_key;
  logic [127:0] cur_k0;

  logic         a_busy, a_tx, a_last, b_busy, b_tx, b_last;
  logic [127:0] a_key, b_key;
  logic [3:0]   a_round, b_round;

  int checks   = 0;
  int failures = 0;
  bit run_chk  = 1'b0;

  always #5 clock = ~clock;

  inv_key_expansion #(.NR(10), .EMIT_LAST(1'b1)) u_a (
    .clock(clock), .reset(reset), .i_tx_en(i_tx_en), .i_key(i_key), .i_stall(i_stall),
    .o_busy(a_busy), .o_tx_en(a_tx), .o_round_key(a_key), .o_round(a_round), .o_last(a_last)
  );

  inv_key_expansion #(.NR(10), .EMIT_LAST(1'b0)) u_b (
    .clock(clock), .reset(reset), .i_tx_en(i_tx_en), .i_key(i_key), .i_stall(i_stall),
    .o_busy(b_busy), .o_tx_en(b_tx), .o_round_key(b_key), .o_round(b_round), .o_last(b_last)
  );

  // Reference: S-box from GF(2^8) inversion plus affine map, keys from the forward schedule.
  logic [7:0] m_sbox [0:255];

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k0, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 4*r+4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Transaction schedule per instance: 0 idle, 1 showing a key, 2 pipeline bubble.
  // Unit u emits rounds (10-u) down to 0; m_idx is the position in that list.
  int           m_mode [2] = '{0, 0};
  int           m_idx  [2] = '{0, 0};
  logic [127:0] m_k0   [2];
  bit           m_rst = 1'b0;

  always @(posedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        m_mode[u] = 0;
      end else begin
        case (m_mode[u])
          0: if (i_tx_en) begin
               m_k0[u]   = cur_k0;
               m_idx[u]  = 0;
               m_mode[u] = (PIPE && u == 1) ? 2 : 1;
             end
          1: if (!i_stall) begin
               if ((10 - u) - m_idx[u] == 0) begin
                 m_mode[u] = 0;
               end else begin
                 m_idx[u]  = m_idx[u] + 1;
                 m_mode[u] = PIPE ? 2 : 1;
               end
             end
          default: m_mode[u] = 1;
        endcase
      end
    end
    m_rst = reset;
  end

  task automatic check_unit(input int u, input logic busy, input logic tx, input logic [127:0] key,
                            input logic [3:0] rnd, input logic last);
    int r;
    bit vld;
    vld = (m_mode[u] == 1);
    r   = (10 - u) - m_idx[u];
    chk($sformatf("u%0d_busy", u), 128'(busy), 128'(m_mode[u] != 0));
    chk($sformatf("u%0d_tx_en", u), 128'(tx), 128'(vld));
    chk($sformatf("u%0d_last", u), 128'(last), 128'(vld && r == 0));
    if (vld) begin
      chk($sformatf("u%0d_round", u), 128'(rnd), 128'(r));
      chk($sformatf("u%0d_key_r%0d", u, r), key, round_key(m_k0[u], r));
    end
    if (m_rst) begin
      chk($sformatf("u%0d_reset_key", u), key, 128'h0);
      chk($sformatf("u%0d_reset_round", u), 128'(rnd), 128'h0);
    end
  endtask

  // Compare both instances against the schedule on every cycle.
  always @(negedge clock) begin
    if (run_chk) begin
      check_unit(0, a_busy, a_tx, a_key, a_round, a_last);
      check_unit(1, b_busy, b_tx, b_key, b_round, b_last);
    end
  end

  task automatic start(input logic [127:0] k0);
    cur_k0  = k0;
    i_key   = round_key(k0, 10);
    i_tx_en = 1'b1;
    @(negedge clock);
    i_tx_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((a_busy || b_busy) && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s: busy=%b%b after 200 cycles, want 00", nm, a_busy, b_busy);
    end
  endtask

  task automatic wait_a_round(input logic [3:0] r, input string nm);
    int n;
    n = 0;
    while (!(a_tx && a_round == r) && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL %s: round %0d never shown (round=%0d tx_en=%b)", nm, r, a_round, a_tx);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] inv;
    int n;
    reset   = 1'b1;
    i_tx_en = 1'b0;
    i_stall = 1'b0;
    i_key   = '0;
    cur_k0  = '0;

    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      m_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    chk("pin_sbox_00", 128'(m_sbox[0]), 128'h63);
    chk("pin_sbox_53", 128'(m_sbox[8'h53]), 128'hed);
    chk("pin_tkf_r10", round_key(K_TKF, 10), 128'h28FDDEF86DA4244ACCC0A4FE3B316F26);
    chk("pin_fips_r10", round_key(K_FIPS, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("pin_fips_r9", round_key(K_FIPS, 9), 128'hac7766f319fadc2128d12941575c006e);

    repeat (3) @(negedge clock);
    run_chk = 1'b1;
    reset   = 1'b0;

    // Known vector: Thats my Kung Fu.
    wait_idle("idle_after_reset");
    start(K_TKF);
    wait_a_round(4'd0, "tkf_last");
    chk("tkf_r0_key", a_key, K_TKF);
    chk("tkf_r0_last", 128'(a_last), 128'd1);
    @(negedge clock);
    chk("tkf_busy_after_last", 128'(a_busy), 128'd0);

    // FIPS-197 vector.
    wait_idle("idle_fips");
    start(K_FIPS);
    wait_a_round(4'd9, "fips_r9");
    chk("fips_r9_key", a_key, 128'hac7766f319fadc2128d12941575c006e);
    wait_a_round(4'd0, "fips_r0");
    chk("fips_r0_key", a_key, K_FIPS);

    // Stall three cycles at round 5.
    wait_idle("idle_stall");
    start(rand_key());
    wait_a_round(4'd5, "stall_r5");
    i_stall = 1'b1;
    repeat (3) @(negedge clock);
    i_stall = 1'b0;
    chk("stall_round_held", 128'(a_round), 128'd5);
    chk("stall_tx_held", 128'(a_tx), 128'd1);

    // Starts while busy are ignored; the cycle after busy falls accepts one.
    wait_idle("idle_ignore");
    start(rand_key());
    wait_a_round(4'd7, "ignore_r7");
    cur_k0  = rand_key();
    i_key   = round_key(cur_k0, 10);
    i_tx_en = 1'b1;
    @(negedge clock);
    i_tx_en = 1'b0;
    wait_a_round(4'd0, "ignore_last");
    cur_k0  = rand_key();
    i_key   = round_key(cur_k0, 10);
    i_tx_en = 1'b1;
    @(negedge clock);
    i_tx_en = 1'b0;
    chk("ignore_idle_after_last", 128'(a_busy), 128'd0);
    start(rand_key());
    chk("b2b_start_tx", 128'(a_tx), 128'd1);
    chk("b2b_start_round", 128'(a_round), 128'd10);

    // Reset in the middle of a sequence.
    wait_idle("idle_reset");
    start(rand_key());
    wait_a_round(4'd6, "reset_r6");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_busy", 128'(a_busy), 128'd0);
    chk("midreset_tx", 128'(a_tx), 128'd0);
    chk("midreset_key", a_key, 128'h0);
    chk("midreset_b_busy", 128'(b_busy), 128'd0);
    start(rand_key());
    wait_idle("after_reset_seq");

    // Random keys with random stalls and ignored start pulses.
    for (int it = 0; it < 60; it++) begin
      wait_idle("rand_idle");
      start(rand_key());
      n = 0;
      while ((a_busy || b_busy) && n < 200) begin
        i_stall = ($urandom_range(0, 3) == 0);
        if (a_busy && b_busy && $urandom_range(0, 9) == 0) begin
          cur_k0  = rand_key();
          i_key   = round_key(cur_k0, 10);
          i_tx_en = 1'b1;
        end else begin
          i_tx_en = 1'b0;
        end
        @(negedge clock);
        n++;
      end
      i_stall = 1'b0;
      i_tx_en = 1'b0;
      checks++;
      if (n >= 200) begin
        failures++;
        $display("FAIL rand_seq_%0d: still busy after 200 cycles, want idle", it);
      end
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
